sequencer: RTL and testbench



---
 rtl/sequencer.sv | 81 ++++++++
 tb/tb_sequencer.sv | 130 +++++++++++++
 2 files changed

// File: rtl/sequencer.sv
// Control FSM for the shift-and-add multiplier: sequences clear, WIDTH test/add/shift
// iterations, then returns to idle. Outputs are registered copies of the next-state decode.
module sequencer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic clock,
  input  logic seqreset,
  input  logic start,
  input  logic Q0,
  output logic reset,
  output logic add,
  output logic shift,
  output logic ready
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_TEST,
    S_ADD,
    S_SHIFT
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          reset_q, reset_d;
  logic          add_q, add_d;
  logic          shift_q, shift_d;
  logic          ready_q, ready_d;

  always_ff @(posedge clock or posedge seqreset) begin
    if (seqreset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      reset_q <= 1'b0;
      add_q   <= 1'b0;
      shift_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      reset_q <= reset_d;
      add_q   <= add_d;
      shift_q <= shift_d;
      ready_q <= ready_d;
    end
  end

  // Next state; outputs are decoded from the next state so the flops hold the Moore value.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_INIT;
      S_INIT: begin
        count_d = CW'(WIDTH);
        state_d = S_TEST;
      end
      S_TEST:  state_d = Q0 ? S_ADD : S_SHIFT;
      S_ADD:   state_d = S_SHIFT;
      S_SHIFT: begin
        count_d = count_q - CW'(1);
        state_d = (count_q == CW'(1)) ? S_IDLE : S_TEST;
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
    reset_d = (state_d == S_INIT);
    add_d   = (state_d == S_ADD);
    shift_d = (state_d == S_SHIFT);
  end

  assign reset = reset_q;
  assign add   = add_q;
  assign shift = shift_q;
  assign ready = ready_q;

endmodule

// File: tb/tb_sequencer.sv
// Randomized bench for sequencer: a per-operation expected strobe trace is built from the
// multiplier's iteration rules and compared cycle by cycle, plus latency and pulse counts.
module tb_sequencer;

  localparam int unsigned WIDTH = 8;

  logic clock = 1'b0;
  logic seqreset, start, Q0;
  logic reset, add, shift, ready;

  int n_checks = 0;
  int n_errors = 0;

  sequencer #(.WIDTH(WIDTH)) dut (
    .clock   (clock),
    .seqreset(seqreset),
    .start   (start),
    .Q0      (Q0),
    .reset   (reset),
    .add     (add),
    .shift   (shift),
    .ready   (ready)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({ready, reset, add, shift});
  endfunction

  // Reset asserted between edges during a SHIFT cycle must idle the outputs immediately.
  task automatic do_async_reset();
    #1 seqreset = 1'b1;
    start = 1'b0;
    #1 check_eq("async_outs", outs(), 32'h8);
    @(posedge clock);
    #1 check_eq("async_hold", outs(), 32'h8);
    @(negedge clock);
    seqreset = 1'b0;
    @(negedge clock);
    check_eq("post_reset_idle", outs(), 32'h8);
  endtask

  // mode: 0 start only at launch, 1 random start noise while busy, 2 start held throughout.
  task automatic run_op(input logic [WIDTH-1:0] bits, input int mode, input bit abort);
    logic [3:0] exp_q[$];
    int         q0_q[$];
    int         ones = 0;
    int         n_add = 0;
    int         n_shift = 0;
    int         busy = 0;
    int         n_sh_seen = 0;

    exp_q.push_back(4'b0100); q0_q.push_back(2);
    for (int i = 0; i < int'(WIDTH); i++) begin
      exp_q.push_back(4'b0000); q0_q.push_back(int'(bits[i]));
      if (bits[i]) begin
        exp_q.push_back(4'b0010); q0_q.push_back(2);
        ones++;
      end
      exp_q.push_back(4'b0001); q0_q.push_back(2);
    end

    start = 1'b1;
    Q0    = 1'($urandom);
    @(posedge clock);
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clock);
      check_eq("trace", outs(), 32'(exp_q[k]));
      if (!ready) busy++;
      if (add) n_add++;
      if (shift) n_shift++;
      Q0    = (q0_q[k] == 2) ? 1'($urandom) : 1'(q0_q[k]);
      start = (mode == 2) ? 1'b1 : (mode == 1) ? 1'($urandom) : 1'b0;
      if (abort && exp_q[k] == 4'b0001) begin
        n_sh_seen++;
        if (n_sh_seen == 3) begin
          do_async_reset();
          return;
        end
      end
    end
    @(negedge clock);
    check_eq("done_idle", outs(), 32'h8);
    check_eq("busy_cycles", 32'(busy), 32'(1 + 2 * (int'(WIDTH) - ones) + 3 * ones));
    check_eq("add_count", 32'(n_add), 32'(ones));
    check_eq("shift_count", 32'(n_shift), 32'(WIDTH));
    start = (mode == 2);
  endtask

  initial begin
    seqreset = 1'b1;
    start    = 1'b0;
    Q0       = 1'b0;
    #1 check_eq("reset_outs", outs(), 32'h8);
    repeat (2) @(negedge clock);
    seqreset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check_eq("idle", outs(), 32'h8);
    end

    run_op(8'h00, 1, 1'b0);
    run_op(8'hFF, 0, 1'b0);
    run_op(8'b01001101, 1, 1'b0);
    run_op(WIDTH'($urandom), 2, 1'b0);
    run_op(WIDTH'($urandom), 0, 1'b0);
    run_op(8'hA5, 0, 1'b1);
    run_op(8'h00, 0, 1'b0);
    for (int n = 0; n < 20; n++)
      run_op(WIDTH'($urandom), int'($urandom_range(0, 2)), 1'b0);
    run_op(WIDTH'($urandom), 0, 1'b0);
    repeat (3) begin
      @(negedge clock);
      check_eq("final_idle", outs(), 32'h8);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
